// File: rtl/load_store_sequencer.sv
// load_store_sequencer: multi-cycle control FSM for the D-form lwz/stw datapath.
// Walks each accepted instruction through DECODE, EXEC, MEM (MEM_LAT cycles) and WB,
// producing Moore-style enables for the register file, ALU and data memory.
// Optional feature macro: LSU_UPDATE_FORM_EN adds lwzu/stwu (opcodes 33/37) and the UPD state.
module load_store_sequencer #(
    parameter int          N       = 32,
    parameter int          MEM_LAT = 1,
    parameter logic [3:0]  ALU_ADD = 4'b0010
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [N-1:0] instruction,
    output logic [4:0]   read_reg_1,
    output logic [4:0]   read_reg_2,
    output logic [4:0]   write_reg,
    output logic [3:0]   ALU_OP,
    output logic         RegWrite,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         wb_sel,
    output logic         done,
    output logic         illegal
);

    localparam int              CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(MEM_LAT - 1);

    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_STW  = 6'd36;
`ifdef LSU_UPDATE_FORM_EN
    localparam logic [5:0] OP_LWZU = 6'd33;
    localparam logic [5:0] OP_STWU = 6'd37;
`endif

`ifdef LSU_UPDATE_FORM_EN
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_UPD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    op_q;
    logic [4:0]    rt_q;
    logic [4:0]    ra_q;
    logic          is_load;
    logic          is_upd;
    logic          legal;

    // The displacement is consumed straight from the fetch path by the datapath's
    // sign extender; the sequencer itself only needs opcode and register fields.
    logic [15:0]   unused_d;
    assign unused_d = instruction[15:0];

    // Opcode classification from the latched fields only.
    always_comb begin
        is_load = 1'b0;
        is_upd  = 1'b0;
        legal   = 1'b0;
`ifdef LSU_UPDATE_FORM_EN
        is_load = (op_q == OP_LWZ) || (op_q == OP_LWZU);
        is_upd  = (op_q == OP_LWZU) || (op_q == OP_STWU);
        // RA=0 has no base register to update, so the update forms reject it.
        legal   = (op_q == OP_LWZ) || (op_q == OP_STW) || (is_upd && (ra_q != 5'd0));
`else
        is_load = (op_q == OP_LWZ);
        legal   = (op_q == OP_LWZ) || (op_q == OP_STW);
`endif
    end

    // State register, MEM-latency counter and instruction field latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            rt_q  <= '0;
            ra_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && instr_valid) begin
                op_q <= instruction[31:26];
                rt_q <= instruction[25:21];
                ra_q <= instruction[20:16];
            end
            if (state == S_MEM)
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        write_reg   = 5'd0;
        ALU_OP      = 4'b0000;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        wb_sel      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        read_reg_1  = (state != S_IDLE) ? ra_q : 5'd0;
        read_reg_2  = (state != S_IDLE) ? rt_q : 5'd0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                ALU_OP    = ALU_ADD;
                state_nxt = S_MEM;
            end
            S_MEM: begin
                ALU_OP   = ALU_ADD;
                MemRead  = is_load;
                MemWrite = !is_load;
                if (cnt == LAST)
                    state_nxt = S_WB;
            end
            S_WB: begin
                ALU_OP = ALU_ADD;
                if (is_load) begin
                    // Keep the read asserted so readData is valid while the RF writes.
                    MemRead   = 1'b1;
                    RegWrite  = 1'b1;
                    write_reg = rt_q;
                end
`ifdef LSU_UPDATE_FORM_EN
                if (is_upd) begin
                    state_nxt = S_UPD;
                end else begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
`else
                done      = 1'b1;
                state_nxt = S_IDLE;
`endif
            end
`ifdef LSU_UPDATE_FORM_EN
            S_UPD: begin
                // Write the effective address back into RA.
                ALU_OP    = ALU_ADD;
                RegWrite  = 1'b1;
                wb_sel    = 1'b1;
                write_reg = ra_q;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: a MEM_LAT=1 instance drives a small
// register-file/memory model, a MEM_LAT=3 instance shares the same inputs.
module tb_load_store_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;

    logic        rdy1, rw1, mr1, mw1, wbs1, dn1, ill1;
    logic [4:0]  rr1_1, rr2_1, wr1;
    logic [3:0]  alu1;
    logic        rdy3, rw3, mr3, mw3, wbs3, dn3, ill3;
    logic [4:0]  rr1_3, rr2_3, wr3;
    logic [3:0]  alu3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_sequencer #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy1),
        .instruction(instruction), .read_reg_1(rr1_1), .read_reg_2(rr2_1),
        .write_reg(wr1), .ALU_OP(alu1), .RegWrite(rw1), .MemRead(mr1),
        .MemWrite(mw1), .wb_sel(wbs1), .done(dn1), .illegal(ill1));

    load_store_sequencer #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy3),
        .instruction(instruction), .read_reg_1(rr1_3), .read_reg_2(rr2_3),
        .write_reg(wr3), .ALU_OP(alu3), .RegWrite(rw3), .MemRead(mr3),
        .MemWrite(mw3), .wb_sel(wbs3), .done(dn3), .illegal(ill3));

    // {ready, ALU_OP, RegWrite, MemRead, MemWrite, wb_sel, done, illegal}
    wire [10:0] sig1 = {rdy1, alu1, rw1, mr1, mw1, wbs1, dn1, ill1};
    wire [10:0] sig3 = {rdy3, alu3, rw3, mr3, mw3, wbs3, dn3, ill3};

    // Datapath model for dut1: RF, word memory, EA adder.
    logic [31:0] rf  [32];
    logic [31:0] mem [256];
    logic [15:0] d_cur = '0;
    logic        loaded = 1'b0;
    wire  [31:0] ea = rf[rr1_1] + {{16{d_cur[15]}}, d_cur};

    // Preload once at the first reset, then apply the sequencer's enables.
    always @(posedge clk) begin
        if (rst && !loaded) begin
            for (int i = 0; i < 32; i++)  rf[i]  <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            rf[2]    <= 32'd100;
            rf[3]    <= 32'h0000_DEAD;
            rf[5]    <= 32'd50;
            rf[6]    <= 32'd60;
            mem[101] <= 32'd8;
            mem[108] <= 32'h77;
            mem[60]  <= 32'h1111;
            loaded   <= 1'b1;
        end else if (!rst) begin
            if (mw1) mem[ea[7:0]] <= rf[rr2_1];
            if (rw1) rf[wr1] <= wbs1 ? ea : mem[ea[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer one instruction for a single accept edge; returns in cycle 1.
    task automatic issue(input logic [5:0] op, input logic [4:0] rt,
                         input logic [4:0] ra, input logic [15:0] d);
        instruction = {op, rt, ra, d};
        d_cur       = d;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    localparam logic [10:0] S_IDL = 11'b1_0000_000000;
    localparam logic [10:0] S_DEC = 11'b0_0000_000000;
    localparam logic [10:0] S_EXE = 11'b0_0010_000000;

    initial begin
        idle(2);
        rst = 1'b0;
        // Reset state
        chk("rst_sig1", sig1, S_IDL);
        chk("rst_sig3", sig3, S_IDL);
        chk("rst_regs", {rr1_1, rr2_1, wr1}, 15'd0);
        idle(1);

        // lwz R1,1(R2)
        issue(6'd32, 5'd1, 5'd2, 16'd1);
        chk("lwz_c1", sig1, S_DEC);
        chk("lwz_rr1", rr1_1, 5'd2);
        step(); chk("lwz_c2", sig1, S_EXE);
        step(); chk("lwz_c3", sig1, 11'b0_0010_010000);
        step(); chk("lwz_c4", sig1, 11'b0_0010_110010);
        chk("lwz_wr", wr1, 5'd1);
        step(); chk("lwz_c5", sig1, S_IDL);
        chk("lwz_r1", rf[1], 32'd8);
        idle(8);

        // stw R3,-4(R5)
        issue(6'd36, 5'd3, 5'd5, 16'hFFFC);
        chk("stw_c1", sig1, S_DEC);
        step(); chk("stw_c2", sig1, S_EXE);
        step(); chk("stw_c3", sig1, 11'b0_0010_001000);
        chk("stw_rr2", rr2_1, 5'd3);
        step(); chk("stw_c4", sig1, 11'b0_0010_000010);
        step(); chk("stw_c5", sig1, S_IDL);
        chk("stw_mem", mem[46], 32'h0000_DEAD);
        idle(8);

        // Illegal opcode
        issue(6'b011111, 5'd1, 5'd2, 16'd0);
        chk("ill_c1", sig1, 11'b0_0000_000001);
        chk("ill3_c1", sig3, 11'b0_0000_000001);
        step(); chk("ill_c2", sig1, S_IDL);
        idle(4);

`ifdef LSU_UPDATE_FORM_EN
        // lwzu R1,8(R2)
        issue(6'd33, 5'd1, 5'd2, 16'd8);
        chk("lwzu_c1", sig1, S_DEC);
        idle(3);
        chk("lwzu_c4", sig1, 11'b0_0010_110000);
        chk("lwzu_wr4", wr1, 5'd1);
        step(); chk("lwzu_c5", sig1, 11'b0_0010_100110);
        chk("lwzu_wr5", wr1, 5'd2);
        step(); chk("lwzu_c6", sig1, S_IDL);
        chk("lwzu_r1", rf[1], 32'h77);
        chk("lwzu_r2", rf[2], 32'd108);
        idle(8);
        issue(6'd33, 5'd1, 5'd0, 16'd8);
        chk("lwzu_ra0", sig1, 11'b0_0000_000001);
        idle(8);
`else
        // Update forms rejected without the feature
        issue(6'd33, 5'd1, 5'd2, 16'd8);
        chk("lwzu_off", sig1, 11'b0_0000_000001);
        idle(4);
        issue(6'd37, 5'd3, 5'd2, 16'd8);
        chk("stwu_off", sig1, 11'b0_0000_000001);
        idle(4);
`endif

        // MEM_LAT=3 lwz R7,0(R2) with instruction churn while busy
        issue(6'd32, 5'd7, 5'd2, 16'd0);
        instruction = 32'hFFFF_FFFF;
        chk("lat3_c1", sig3, S_DEC);
        step(); chk("lat3_c2", sig3, S_EXE);
        instruction = {6'd36, 5'd9, 5'd9, 16'd0};
        for (int c = 3; c <= 5; c++) begin
            step(); chk($sformatf("lat3_c%0d", c), sig3, 11'b0_0010_010000);
        end
        step(); chk("lat3_c6", sig3, 11'b0_0010_110010);
        chk("lat3_wr", wr3, 5'd7);
        chk("lat3_rr1", rr1_3, 5'd2);
        step(); chk("lat3_c7", sig3, S_IDL);
        idle(8);

        // Back-to-back with instr_valid held: lwz R8,1(R2)
        instruction = {6'd32, 5'd8, 5'd2, 16'd1};
        d_cur       = 16'd1;
        instr_valid = 1'b1;
        idle(4);
        chk("b2b_done1", sig1, 11'b0_0010_110010);
        step(); chk("b2b_c5", sig1, S_IDL);
        step(); chk("b2b_c6", sig1, S_DEC);
        instr_valid = 1'b0;
        idle(3);
        chk("b2b_done2", dn1, 1'b1);
        chk("b2b_r8", rf[8], 32'd8);
        idle(8);

        // Reset during MEM of stw R3,0(R6)
        issue(6'd36, 5'd3, 5'd6, 16'd0);
        idle(2);
        chk("rst_mem_c3", mw1, 1'b1);
        rst = 1'b1;
        step();
        chk("rst_mem_c4", sig1, S_IDL);
        chk("rst_mem_word", mem[60], 32'h1111);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); chk("rst_nodone", {dn1, mw1, rdy1}, 3'b001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
